// File: rtl/vram_rect_fill_pkg.sv
// Shared display definitions: screen geometry, VRAM field widths and the fill FSM encoding.
// The VGA scan-out path imports the same geometry so both agree on the row pitch.
package vram_rect_fill_pkg;

    localparam int DISP_SCREEN_W = 512;
    localparam int DISP_SCREEN_H = 480;

    localparam int CMD_X_W   = 10;
    localparam int CMD_Y_W   = 9;
    localparam int BOUND_W   = 11;
    localparam int ADDR_W    = 18;
    localparam int COLOR_W   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fillState_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major column/row stepper over a rectangle [colStart, colEnd) x [rowStart, rowEnd).
// o_col/o_row present the position the registers will hold after this edge, so a caller can register its address in the same cycle.
module rect_scan_counter #(
    parameter int COL_W = 10,
    parameter int ROW_W = 9,
    parameter int BND_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [COL_W-1:0] i_colStart,
    input  logic [ROW_W-1:0] i_rowStart,
    input  logic [BND_W-1:0] i_colEnd,
    input  logic [BND_W-1:0] i_rowEnd,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_last
);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_colStart;
    logic [BND_W-1:0] r_colEnd;
    logic [BND_W-1:0] r_rowEnd;

    logic             w_colWrap;
    logic             w_rowWrap;
    logic [COL_W-1:0] w_colNext;
    logic [ROW_W-1:0] w_rowNext;

    always_comb begin
        w_colWrap = (BND_W'(r_col) + BND_W'(1)) == r_colEnd;
        w_rowWrap = (BND_W'(r_row) + BND_W'(1)) == r_rowEnd;
        o_last    = w_colWrap && w_rowWrap;
    end

    always_comb begin
        w_colNext = r_col;
        w_rowNext = r_row;
        if (i_load) begin
            w_colNext = i_colStart;
            w_rowNext = i_rowStart;
        end else if (i_step) begin
            if (w_colWrap) begin
                w_colNext = r_colStart;
                w_rowNext = r_row + ROW_W'(1);
            end else begin
                w_colNext = r_col + COL_W'(1);
            end
        end
        o_col = w_colNext;
        o_row = w_rowNext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_colStart <= '0;
            r_colEnd   <= '0;
            r_rowEnd   <= '0;
        end else begin
            r_col <= w_colNext;
            r_row <= w_rowNext;
            if (i_load) begin
                r_colStart <= i_colStart;
                r_colEnd   <= i_colEnd;
                r_rowEnd   <= i_rowEnd;
            end
        end
    end

endmodule

// File: rtl/vram_rect_fill.sv
// Solid rectangle fill into VRAM: one clipped pixel written per cycle in row-major order.
// The first write is issued straight from the command fields so it appears the cycle after accept.
module vram_rect_fill
    import vram_rect_fill_pkg::*;
#(
    parameter int SCREEN_W = DISP_SCREEN_W,
    parameter int SCREEN_H = DISP_SCREEN_H
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CMD_X_W-1:0] cmd_x,
    input  logic [CMD_Y_W-1:0] cmd_y,
    input  logic [CMD_X_W-1:0] cmd_w,
    input  logic [CMD_Y_W-1:0] cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic               vram_we,
    output logic [ADDR_W-1:0]  vram_waddr,
    output logic [COLOR_W-1:0] vram_wdata,
    output logic               busy,
    output logic               done
);

    localparam bit W_IS_POW2 = (SCREEN_W & (SCREEN_W - 1)) == 0;
    localparam int W_SHIFT   = $clog2(SCREEN_W);

    fillState_t          r_state;
    fillState_t          w_nextState;

    logic [BOUND_W-1:0]  w_xSum;
    logic [BOUND_W-1:0]  w_ySum;
    logic [BOUND_W-1:0]  w_xEnd;
    logic [BOUND_W-1:0]  w_yEnd;
    logic                w_empty;
    logic                w_accept;
    logic                w_step;
    logic                w_last;
    logic                w_weNext;
    logic [CMD_X_W-1:0]  w_col;
    logic [CMD_Y_W-1:0]  w_row;
    logic [ADDR_W-1:0]   w_rowBase;
    logic [ADDR_W-1:0]   w_addrNext;

    // Sums are one bit wider than the fields so an oversized rectangle clips instead of wrapping.
    always_comb begin
        w_xSum  = BOUND_W'(cmd_x) + BOUND_W'(cmd_w);
        w_ySum  = BOUND_W'(cmd_y) + BOUND_W'(cmd_h);
        w_xEnd  = (w_xSum > BOUND_W'(SCREEN_W)) ? BOUND_W'(SCREEN_W) : w_xSum;
        w_yEnd  = (w_ySum > BOUND_W'(SCREEN_H)) ? BOUND_W'(SCREEN_H) : w_ySum;
        w_empty = (cmd_w == '0) || (cmd_h == '0) ||
                  (BOUND_W'(cmd_x) >= BOUND_W'(SCREEN_W)) ||
                  (BOUND_W'(cmd_y) >= BOUND_W'(SCREEN_H));
    end

    rect_scan_counter #(
        .COL_W (CMD_X_W),
        .ROW_W (CMD_Y_W),
        .BND_W (BOUND_W)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_colStart (cmd_x),
        .i_rowStart (cmd_y),
        .i_colEnd   (w_xEnd),
        .i_rowEnd   (w_yEnd),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_last     (w_last)
    );

    generate
        if (W_IS_POW2) begin : g_rowShift
            assign w_rowBase = ADDR_W'(w_row) << W_SHIFT;
        end else begin : g_rowMul
            assign w_rowBase = ADDR_W'(w_row) * ADDR_W'(SCREEN_W);
        end
    endgenerate

    assign w_addrNext = w_rowBase + ADDR_W'(w_col);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_nextState = w_empty ? DONE : FILL;
            FILL:    if (w_last)    w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        w_accept  = cmd_ready && cmd_valid;
        w_step    = (r_state == FILL) && !w_last;
        w_weNext  = (w_accept && !w_empty) || w_step;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vram_we    <= 1'b0;
            vram_waddr <= '0;
            vram_wdata <= '0;
        end else begin
            vram_we <= w_weNext;
            if (w_weNext) begin
                vram_waddr <= w_addrNext;
            end
            if (w_accept) begin
                vram_wdata <= cmd_color;
            end
        end
    end

endmodule
